// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, operand select and ALU control.
// Also raises the load-use hazard request toward the hazard unit.
module id_ex_stage #(
  parameter int D_WIDTH = 32,
  parameter int R_ADDR  = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [6:0]         id_opcode_i,
  input  logic [2:0]         id_funct3_i,
  input  logic               id_funct7b5_i,
  input  logic [R_ADDR-1:0]  id_rs1_i,
  input  logic [R_ADDR-1:0]  id_rs2_i,
  input  logic [R_ADDR-1:0]  id_rd_i,
  input  logic [D_WIDTH-1:0] id_rs1_data_i,
  input  logic [D_WIDTH-1:0] id_rs2_data_i,
  input  logic [D_WIDTH-1:0] id_imm_i,
  input  logic [D_WIDTH-1:0] id_pc_i,
  input  logic               exm_regwrite_i,
  input  logic [R_ADDR-1:0]  exm_rd_i,
  input  logic [D_WIDTH-1:0] exm_result_i,
  input  logic               mwb_regwrite_i,
  input  logic [R_ADDR-1:0]  mwb_rd_i,
  input  logic [D_WIDTH-1:0] mwb_data_i,
  output logic [D_WIDTH-1:0] oprnd1_o,
  output logic [D_WIDTH-1:0] oprnd2_o,
  output logic [3:0]         alu_ctrl_o,
  output logic [D_WIDTH-1:0] store_data_o,
  output logic               ex_valid_o,
  output logic [R_ADDR-1:0]  ex_rd_o,
  output logic               ex_regwrite_o,
  output logic [6:0]         ex_opcode_o,
  output logic [2:0]         ex_funct3_o,
  output logic               load_use_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam int SH = $clog2(D_WIDTH);

  typedef struct packed {
    logic               valid;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [R_ADDR-1:0]  rs1;
    logic [R_ADDR-1:0]  rs2;
    logic [R_ADDR-1:0]  rd;
    logic [D_WIDTH-1:0] rs1_data;
    logic [D_WIDTH-1:0] rs2_data;
    logic [D_WIDTH-1:0] imm;
    logic [D_WIDTH-1:0] pc;
  } id_ex_t;

  id_ex_t q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (flush_i) begin
      q.valid <= 1'b0;
    end else if (!stall_i) begin
      q.valid    <= id_valid_i;
      q.opcode   <= id_opcode_i;
      q.funct3   <= id_funct3_i;
      q.funct7b5 <= id_funct7b5_i;
      q.rs1      <= id_rs1_i;
      q.rs2      <= id_rs2_i;
      q.rd       <= id_rd_i;
      q.rs1_data <= id_rs1_data_i;
      q.rs2_data <= id_rs2_data_i;
      q.imm      <= id_imm_i;
      q.pc       <= id_pc_i;
    end
  end

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;

  assign is_lui   = q.opcode == OP_LUI;
  assign is_auipc = q.opcode == OP_AUIPC;
  assign is_jal   = q.opcode == OP_JAL;
  assign is_jalr  = q.opcode == OP_JALR;
  assign is_br    = q.opcode == OP_BRANCH;
  assign is_ld    = q.opcode == OP_LOAD;
  assign is_st    = q.opcode == OP_STORE;
  assign is_opi   = q.opcode == OP_IMM;
  assign is_op    = q.opcode == OP_REG;

  // x0 never forwards; EX/MEM is younger so it wins over MEM/WB
  logic exm_hit1, exm_hit2, mwb_hit1, mwb_hit2;
  logic [D_WIDTH-1:0] fwd1, fwd2, op2_raw;

  assign exm_hit1 = exm_regwrite_i && exm_rd_i != '0 && exm_rd_i == q.rs1;
  assign exm_hit2 = exm_regwrite_i && exm_rd_i != '0 && exm_rd_i == q.rs2;
  assign mwb_hit1 = mwb_regwrite_i && mwb_rd_i != '0 && mwb_rd_i == q.rs1;
  assign mwb_hit2 = mwb_regwrite_i && mwb_rd_i != '0 && mwb_rd_i == q.rs2;

  assign fwd1 = exm_hit1 ? exm_result_i :
                mwb_hit1 ? mwb_data_i   : q.rs1_data;
  assign fwd2 = exm_hit2 ? exm_result_i :
                mwb_hit2 ? mwb_data_i   : q.rs2_data;

  always_comb begin
    oprnd1_o = fwd1;
    unique case (1'b1)
      is_lui:                     oprnd1_o = '0;
      is_auipc, is_jal, is_jalr: oprnd1_o = q.pc;
      default: ;
    endcase
  end

  always_comb begin
    op2_raw = q.imm;
    unique case (1'b1)
      is_op, is_br:    op2_raw = fwd2;
      is_jal, is_jalr: op2_raw = D_WIDTH'(4);
      default: ;
    endcase
  end

  // shift amount uses only the low bits of operand 2
  assign oprnd2_o = ((is_op || is_opi) && q.funct3[1:0] == 2'b01) ?
                    {{(D_WIDTH-SH){1'b0}}, op2_raw[SH-1:0]} : op2_raw;

  always_comb begin
    alu_ctrl_o = 4'b0000;
    unique case (1'b1)
      is_op:  alu_ctrl_o = {q.funct3, q.funct7b5};
      is_opi: alu_ctrl_o = {q.funct3,
                            q.funct7b5 && q.funct3 == 3'b101};
      is_br: begin
        unique case (q.funct3[2:1])
          2'b00:   alu_ctrl_o = 4'b0001;
          2'b10:   alu_ctrl_o = 4'b0100;
          2'b11:   alu_ctrl_o = 4'b0110;
          default: alu_ctrl_o = 4'b0000;
        endcase
      end
      default: ;
    endcase
  end

  assign store_data_o  = fwd2;
  assign ex_valid_o    = q.valid;
  assign ex_rd_o       = q.rd;
  assign ex_opcode_o   = q.opcode;
  assign ex_funct3_o   = q.funct3;
  assign ex_regwrite_o = q.valid && q.rd != '0 && !is_st && !is_br;

  assign load_use_o = q.valid && is_ld && q.rd != '0 && id_valid_i &&
                      (q.rd == id_rs1_i || q.rd == id_rs2_i);

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-operand preparation for the 5-stage RV32I core; sits directly upstream of the ALU and drives its oprnd1/oprnd2/alu_ctrl inputs.
- Latches decoded fields from ID, applies stall/flush, resolves EX/MEM and MEM/WB forwarding, and produces the 4-bit ALU control code.
- Flags load-use hazards back to the hazard unit.

Parameters:
- D_WIDTH, 32, datapath width.
- R_ADDR, 5, register-address width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold current contents
- flush_i  in  1  insert bubble
- id_valid_i  in  1  ID holds a valid instruction
- id_opcode_i  in  7  instruction[6:0]
- id_funct3_i  in  3  instruction[14:12]
- id_funct7b5_i  in  1  instruction[30]
- id_rs1_i, id_rs2_i, id_rd_i  in  R_ADDR each  register addresses
- id_rs1_data_i, id_rs2_data_i  in  D_WIDTH each  register-file read data
- id_imm_i  in  D_WIDTH  sign-extended immediate
- id_pc_i  in  D_WIDTH  instruction PC
- exm_regwrite_i  in  1  EX/MEM writes rd
- exm_rd_i  in  R_ADDR  EX/MEM destination
- exm_result_i  in  D_WIDTH  EX/MEM ALU result
- mwb_regwrite_i  in  1  MEM/WB writes rd
- mwb_rd_i  in  R_ADDR  MEM/WB destination
- mwb_data_i  in  D_WIDTH  MEM/WB writeback data
- oprnd1_o, oprnd2_o  out  D_WIDTH each  ALU operands
- alu_ctrl_o  out  4  ALU operation code
- store_data_o  out  D_WIDTH  forwarded rs2 for stores
- ex_valid_o  out  1  EX holds a valid instruction
- ex_rd_o  out  R_ADDR  destination register
- ex_regwrite_o  out  1  instruction writes rd (rd≠0)
- ex_opcode_o  out  7, ex_funct3_o  out  3  passed downstream
- load_use_o  out  1  load-use hazard request

Behaviour:
- Reset (async, rst_i=1): all registered fields 0. Outputs: ex_valid_o=0, ex_regwrite_o=0, ex_rd_o=0, alu_ctrl_o=4'b0000, oprnd1_o/oprnd2_o/store_data_o=0 when no forwarding matches, load_use_o=0. Reset mid-stall or mid-flush overrides both.
- Clock edge priority: flush_i > stall_i > load. Flush clears valid and regwrite, other fields don't-care. Stall holds every register. Load captures all id_* inputs; valid=id_valid_i.
- Latency: one cycle from ID inputs to registered fields; everything downstream of the registers (forwarding, operand select, alu_ctrl) is combinational.
- Forwarding (rs1 and rs2 independently): EX/MEM wins when exm_regwrite_i=1, exm_rd_i≠0 and it equals the rs address. Otherwise MEM/WB under the same rules. Otherwise registered data. x0 is never forwarded.
- Operand select:
  - oprnd1 = 0 for LUI (0110111); PC for AUIPC/JAL/JALR; otherwise fwd rs1.
  - oprnd2 = fwd rs2 for OP and BRANCH; 4 for JAL/JALR (link value); otherwise imm.
  - Shifts (funct3 001/101 in OP or OP-IMM): oprnd2[31:5] forced 0.
- alu_ctrl:
  - OP: {funct3, funct7b5}.
  - OP-IMM: {funct3, funct7b5 if funct3=101 else 0}.
  - BRANCH: 0001 for funct3 00x; 0100 for 10x; 0110 for 11x.
  - All other opcodes: 0000 (ADD).
  - Codes: 0000 ADD, 0001 SUB, 0010 SLL, 0100 SLT, 0110 SLTU, 1000 XOR, 1010 SRL, 1011 SRA, 1100 OR, 1110 AND.
- ex_regwrite_o = valid AND rd≠0 AND opcode ∉ {STORE, BRANCH}.
- load_use_o: combinational. Asserted when ex_valid_o=1, ex_opcode_o=LOAD (0000011), ex_rd_o≠0 and ex_rd_o equals id_rs1_i or id_rs2_i while id_valid_i=1.
  - The hazard unit answers with stall of IF/ID and flush_i here next edge.
  - stall_i and flush_i together: flush wins.
- Invalid stage (ex_valid_o=0): outputs are don't-care except ex_regwrite_o=0 and load_use_o=0.

Test Plan:
- Reset mid-operation: load ADD, assert rst_i asynchronously between edges -> ex_valid_o=0, alu_ctrl_o=0000 immediately.
- SUB x3,x1,x2 with rs1_data=10, rs2_data=3 -> next cycle alu_ctrl_o=0001, oprnd1_o=10, oprnd2_o=3, ex_regwrite_o=1.
- SRAI imm=0x405 (funct7b5=1) -> alu_ctrl_o=1011, oprnd2_o=5. SLL with rs2_data=0x00000121 -> oprnd2_o=0x01.
- Double-hazard forwarding: rs1=x5, exm_rd=5 result=0xAAAA, mwb_rd=5 data=0xBBBB -> oprnd1_o=0xAAAA. Same with rd=x0 -> registered data used.
- LW x7 in EX, ID has rs2=x7 -> load_use_o=1. Flush next edge -> ex_valid_o=0, ex_regwrite_o=0. Stall+flush together -> bubble.
- LUI imm=0x12345000 -> oprnd1_o=0, oprnd2_o=0x12345000, alu_ctrl_o=0000. BLTU -> alu_ctrl_o=0110, ex_regwrite_o=0.
